g_sweep_ctrl: RTL

G_SWEEP_CTRL -- requirements
Module: g_sweep_ctrl

---
 rtl/g_sweep_pkg.sv | 30 +++
 rtl/g_sweep_ctrl_if.sv | 27 ++
 rtl/g_sweep_ctrl_settle_timer.sv | 45 ++++
 rtl/g_sweep_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/g_sweep_pkg.sv
// g_sweep_pkg: shared definitions for the truth-table sweep controller.
//   state_e      - 2-bit FSM state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   NUM_VECTORS  - number of input vectors swept (8 for a 3-input function)
//   IDX_W        - width of the vector index ({A,B,C})
//   set_bit()    - returns a table with one bit replaced by a sampled value
package g_sweep_pkg;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned IDX_W       = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [NUM_VECTORS-1:0] set_bit(
    input logic [NUM_VECTORS-1:0] tbl,
    input logic [IDX_W-1:0]       idx,
    input logic                   val
  );
    logic [NUM_VECTORS-1:0] res;
    res      = tbl;
    res[idx] = val;
    return res;
  endfunction

endpackage

// File: rtl/g_sweep_ctrl_if.sv
// g_sweep_ctrl_if: control/result bus of the sweep controller.
//   start     - single-cycle sweep request (master -> slave)
//   exp_tbl   - expected truth table, captured on an accepted start
//   busy      - sweep in progress
//   done      - one-cycle completion pulse
//   truth_tbl - captured table, bit i = G for {A,B,C}=i
//   pass      - captured table matched the captured expectation
interface g_sweep_ctrl_if;
  import g_sweep_pkg::*;

  logic                   start;
  logic [NUM_VECTORS-1:0] exp_tbl;
  logic                   busy;
  logic                   done;
  logic [NUM_VECTORS-1:0] truth_tbl;
  logic                   pass;

  modport master (
    output start, exp_tbl,
    input  busy, done, truth_tbl, pass
  );

  modport slave (
    input  start, exp_tbl,
    output busy, done, truth_tbl, pass
  );
endinterface

// File: rtl/g_sweep_ctrl_settle_timer.sv
// settle_timer: counts the cycles an input vector has been held.
//   clk, reset - clock and synchronous active-high reset
//   clear      - restart the count at zero (wins over enable)
//   enable     - count this cycle
//   expired    - high in the last of SETTLE_CYCLES enabled cycles
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear has priority, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count starts at 0 on SETTLE entry, so value N-1 marks the N-th cycle.
  assign expired = enable && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/g_sweep_ctrl.sv
// g_sweep_ctrl: steps a 3-input function through all eight {A,B,C}
// vectors, waits SETTLE_CYCLES per vector, samples G and compares the
// captured truth table against an expected one.
//   clk, reset  - clock and synchronous active-high reset
//   ctrl        - start/exp_tbl in, busy/done/truth_tbl/pass out
//   g_in        - G output of the external function
//   a_out/b_out/c_out - A (msb), B, C drive of the external function
module g_sweep_ctrl
  import g_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  g_sweep_ctrl_if.slave        ctrl,
  input  logic                 g_in,
  output logic                 a_out,
  output logic                 b_out,
  output logic                 c_out
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_VECTORS-1:0] tbl_q, tbl_d;
  logic [NUM_VECTORS-1:0] exp_q, exp_d;
  logic [NUM_VECTORS-1:0] sampled_s;
  logic                   pass_q, pass_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   tmr_clear_s;
  logic                   tmr_en_s;
  logic                   tmr_expired_s;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear_s),
    .enable  (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // Next-state and datapath updates of the sweep FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tbl_d       = tbl_q;
    exp_d       = exp_q;
    pass_d      = pass_q;
    tmr_clear_s = 1'b0;
    tmr_en_s    = 1'b0;
    sampled_s   = set_bit(tbl_q, idx_q, g_in);

    case (state_q)
      ST_IDLE: begin
        if (ctrl.start) begin
          exp_d       = ctrl.exp_tbl;
          idx_d       = 3'd0;
          tbl_d       = 8'h00;
          tmr_clear_s = 1'b1;
          state_d     = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        tmr_en_s = 1'b1;
        if (tmr_expired_s) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        tbl_d = sampled_s;
        if (idx_q == IDX_LAST) begin
          // Compare against the table including this last sample so that
          // pass is already valid while done is high.
          pass_d  = (sampled_s == exp_q);
          state_d = ST_DONE;
        end else begin
          idx_d       = idx_q + 3'd1;
          tmr_clear_s = 1'b1;
          state_d     = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      tbl_q   <= 8'h00;
      exp_q   <= 8'h00;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // idx only moves on SETTLE entry, so it directly drives {A,B,C}.
  assign a_out          = idx_q[2];
  assign b_out          = idx_q[1];
  assign c_out          = idx_q[0];
  assign ctrl.busy      = busy_q;
  assign ctrl.done      = done_q;
  assign ctrl.truth_tbl = tbl_q;
  assign ctrl.pass      = pass_q;

endmodule
